data_ram_ctrl: RTL
==================

Name: data_ram_ctrl

Overview:
- Parametrised single-port data memory for the CPU load/store path.
- Replaces the fixed 16-word, clock-level-gated word RAM with a synchronous memory:
  - byte/half/word accesses with sign or zero extension on loads;
  - a valid/ready request interface and a registered response;
  - misaligned and out-of-range error reporting;
  - a post-reset initialisation sequencer that fills every word before accepting requests.

Parameters:
- DEPTH, 16: number of 32-bit words; power of two, at least 2.
- ADDR_WIDTH, 32: width of the byte address.
- INIT_MODE, 1: 0 writes zero to every word; 1 writes the word index into every word (word i = i).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0; ignored on stores.
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  32  store data; the value sits in the low bits for byte and half stores.
- resp_valid  out  1  one-cycle pulse per accepted request.
- resp_rdata  out  32  extended load data; 0 for stores and on error.
- resp_err  out  1  the accepted request was misaligned, out of range, or used size 3.
- init_done  out  1  initialisation complete.

Behaviour:
- Reset (rst=1 at an edge):
  - state goes to INIT and the init counter goes to 0;
  - req_ready=0, resp_valid=0, resp_rdata=0, resp_err=0, init_done=0.
  - The same applies when reset arrives mid-operation. Any pending response is dropped, not delivered.
- Array contents: undefined before the first INIT pass completes. After that, they change only through INIT or accepted stores.
- State INIT:
  - each cycle, write the INIT_MODE value into word[counter], then increment the counter;
  - after writing word DEPTH-1, go to RUN. That takes DEPTH cycles after reset deasserts;
  - req_ready=0 throughout INIT. req_valid is ignored.
- State RUN:
  - init_done=1 and req_ready=1 in every cycle;
  - a request is accepted when req_valid and req_ready are both 1;
  - throughput is one request per cycle. There is no response back-pressure.
- Address decode:
  - word index = req_addr[log2(DEPTH)+1:2];
  - byte lane = req_addr[1:0].
- Error conditions, any of which sets the error:
  - req_size=3;
  - size=1 with req_addr[0]=1;
  - size=2 with req_addr[1:0]≠0;
  - any req_addr bit at or above log2(DEPTH)+2 is set (out of range).
- Stores:
  - if there is no error, on the accepting edge write only the selected lanes:
    - byte: lane = addr[1:0], data = wdata[7:0];
    - half: lanes addr[1]*2 and addr[1]*2+1, data = wdata[15:0];
    - word: all four lanes.
  - Unselected bytes keep their value.
  - An erroring store writes nothing.
- Loads:
  - read the whole word, select the byte or half by lane, then sign- or zero-extend to 32 bits;
  - an erroring load returns resp_rdata=0.
- Response latency: exactly 1 cycle. For a request accepted at edge N:
  - resp_valid=1 during cycle N+1 (registered after edge N);
  - resp_rdata and resp_err are valid in that same cycle;
  - resp_valid=0 in any cycle that follows a cycle with no acceptance.
- Read after write: a load accepted at edge N+1 returns data that includes a store accepted at edge N. A load accepted at the same edge as a store cannot occur (single port).
- Stable outputs: resp_rdata and resp_err hold their last value while resp_valid=0. Consumers must qualify them with resp_valid.

Test Plan:
- Reset init:
  - stimulus: rst high 2 cycles then low, with DEPTH=16, INIT_MODE=1;
  - required: req_ready=0 for 16 cycles, then init_done=1 and req_ready=1;
  - then word loads at addresses 0x0, 0x3C return 0x0 and 0xF.
- Word and byte mix:
  - stimulus: store word 0x8081_7F01 at 0x8, then load byte signed at 0x8, 0x9, 0xB and byte unsigned at 0xB;
  - required: 0x0000_0001, 0x0000_007F, 0xFFFF_FF80, 0x0000_0080, each arriving 1 cycle after acceptance.
- Partial store:
  - stimulus: word 0x10 initialised to 0x4, store half 0xBEEF at 0x12, then load word at 0x10;
  - required: 0xBEEF_0004. A following signed half load at 0x12 returns 0xFFFF_BEEF.
- Errors:
  - stimulus: store half at 0x5, word load at 0x6, size=3 at 0x0, word load at 0x40 (DEPTH=16);
  - required: resp_err=1 and rdata=0 for each;
  - afterwards, word 0x4 still reads 0x1 (no write occurred).
- Back-to-back:
  - stimulus: 8 consecutive requests with req_valid held high, alternating store and load to the same address;
  - required: resp_valid high for 8 consecutive cycles, and every load returns the immediately preceding store's data.
- Mid-operation reset:
  - stimulus: rst asserted in the cycle a load is accepted;
  - required: no resp_valid pulse, outputs go to 0, INIT reruns, and prior stores are overwritten by the INIT_MODE values.

Source files
------------

// File: rtl/data_ram_ctrl.sv
// Single-port load/store data memory: byte/half/word access with sign/zero extension, error flagging,
// registered 1-cycle response, and a post-reset sequencer that fills every word before requests are taken.
module data_ram_ctrl #(
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 32,
    parameter int INIT_MODE  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_err,
    output logic                  init_done
);

    localparam int IW  = $clog2(DEPTH);
    localparam int AW2 = IW + 2;
    // Any address bit at or above AW2 means the byte address is past the end of the array.
    localparam logic [ADDR_WIDTH-1:0] HI_MASK = ~ADDR_WIDTH'((64'd1 << AW2) - 64'd1);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t         state_q, state_d;
    logic [IW-1:0]  cnt_q, cnt_d;
    logic           resp_valid_q, resp_valid_d;
    logic [31:0]    resp_rdata_q, resp_rdata_d;
    logic           resp_err_q, resp_err_d;

    logic [31:0]    mem [DEPTH];

    logic [IW-1:0]  word_idx;
    logic [1:0]     lane;
    logic           accept;
    logic           req_err;
    logic [31:0]    rd_word;
    logic [7:0]     rd_byte;
    logic [15:0]    rd_half;
    logic [31:0]    load_data;

    logic           mem_we;
    logic [IW-1:0]  mem_idx;
    logic [3:0]     mem_be;
    logic [31:0]    mem_wdat;

    assign word_idx  = req_addr[AW2-1:2];
    assign lane      = req_addr[1:0];
    assign req_ready = (state_q == ST_RUN);
    assign init_done = (state_q == ST_RUN);
    assign accept    = req_valid && req_ready;

    assign req_err = (req_size == 2'd3)
                   || ((req_size == 2'd1) && req_addr[0])
                   || ((req_size == 2'd2) && (lane != 2'b00))
                   || ((req_addr & HI_MASK) != '0);

    assign rd_word = mem[word_idx];
    assign rd_byte = rd_word[{lane, 3'b000} +: 8];
    assign rd_half = req_addr[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        load_data = 32'd0;
        case (req_size)
            2'd0: load_data = req_unsigned ? {24'd0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
            2'd1: load_data = req_unsigned ? {16'd0, rd_half} : {{16{rd_half[15]}}, rd_half};
            2'd2: load_data = rd_word;
            default: load_data = 32'd0;
        endcase
    end

    // Write port is shared by the init sequencer and accepted error-free stores.
    always_comb begin
        mem_we   = 1'b0;
        mem_idx  = word_idx;
        mem_be   = 4'b0000;
        mem_wdat = req_wdata;
        if (!rst && state_q == ST_INIT) begin
            mem_we   = 1'b1;
            mem_idx  = cnt_q;
            mem_be   = 4'b1111;
            mem_wdat = (INIT_MODE == 1) ? 32'(cnt_q) : 32'd0;
        end else if (!rst && accept && req_write && !req_err) begin
            mem_we = 1'b1;
            case (req_size)
                2'd0: begin
                    mem_be   = 4'b0001 << lane;
                    mem_wdat = {4{req_wdata[7:0]}};
                end
                2'd1: begin
                    mem_be   = req_addr[1] ? 4'b1100 : 4'b0011;
                    mem_wdat = {2{req_wdata[15:0]}};
                end
                default: mem_be = 4'b1111;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_be[b]) begin
                    mem[mem_idx][8*b +: 8] <= mem_wdat[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        case (state_q)
            ST_INIT: begin
                cnt_d = cnt_q + IW'(1);
                if (cnt_q == IW'(DEPTH - 1)) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                if (accept) begin
                    resp_valid_d = 1'b1;
                    resp_err_d   = req_err;
                    resp_rdata_d = (req_write || req_err) ? 32'd0 : load_data;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_INIT;
            cnt_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'd0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

endmodule
